// File: rtl/spi_master_driver.sv
// rtl/spi_master_driver.sv - host-side SPI framer for the SPI slave + RAM subsystem
// Serialises one command per frame on SS_n/MOSI and captures read-data words from MISO.
module spi_master_driver #(
  parameter int ADDR_SIZE = 8,
  parameter int MEM_WIDTH = 8,
  parameter int TURN_CYC  = 2,
  parameter int GAP_CYC   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_SIZE+1:0]   cmd_data,
  output logic                   SS_n,
  output logic                   MOSI,
  input  logic                   MISO,
  output logic [MEM_WIDTH-1:0]   rd_data,
  output logic                   rd_valid,
  output logic                   busy
);

  localparam int CMD_W    = ADDR_SIZE + 2;
  localparam int SEND_LEN = ADDR_SIZE + 3;
  localparam int CW       = $clog2(SEND_LEN + TURN_CYC + MEM_WIDTH + GAP_CYC + 2);

  typedef enum logic [2:0] {IDLE, LEAD, SEND, TURN, RECV, GAP} state_e;

  state_e               state_q;
  logic [CW-1:0]        cnt_q;
  logic [CMD_W-1:0]     shreg_q;
  logic                 rd_cmd_q;
  logic [MEM_WIDTH-1:0] rx_q;
  logic [MEM_WIDTH-1:0] rx_d;
  logic                 ss_n_q;
  logic                 mosi_q;
  logic                 cmd_ready_q;
  logic                 busy_q;
  logic                 rd_valid_q;
  logic [MEM_WIDTH-1:0] rd_data_q;

  // MISO only enters the datapath through this shift, and only in RECV.
  assign rx_d = {rx_q[MEM_WIDTH-2:0], MISO};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      rd_cmd_q    <= 1'b0;
      rx_q        <= '0;
      ss_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            shreg_q     <= cmd_data;
            rd_cmd_q    <= (cmd_data[CMD_W-1 -: 2] == 2'b11);
            ss_n_q      <= 1'b0;
            mosi_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= LEAD;
          end
        end
        LEAD: begin
          // The opcode MSB is presented twice: once for CHK_CMD, then as frame bit 9.
          mosi_q  <= shreg_q[CMD_W-1];
          cnt_q   <= '0;
          state_q <= SEND;
        end
        SEND: begin
          if (cnt_q == CW'(SEND_LEN - 1)) begin
            mosi_q <= 1'b0;
            cnt_q  <= '0;
            if (rd_cmd_q) begin
              state_q <= TURN;
            end else begin
              ss_n_q  <= 1'b1;
              state_q <= GAP;
            end
          end else begin
            mosi_q  <= shreg_q[CMD_W-1];
            shreg_q <= {shreg_q[CMD_W-2:0], 1'b0};
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        TURN: begin
          if (cnt_q == CW'(TURN_CYC - 1)) begin
            cnt_q   <= '0;
            state_q <= RECV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RECV: begin
          rx_q <= rx_d;
          if (cnt_q == CW'(MEM_WIDTH - 1)) begin
            rd_data_q  <= rx_d;
            rd_valid_q <= 1'b1;
            ss_n_q     <= 1'b1;
            cnt_q      <= '0;
            state_q    <= GAP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        GAP: begin
          if (cnt_q == CW'(GAP_CYC - 1)) begin
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign SS_n      = ss_n_q;
  assign MOSI      = mosi_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign busy      = busy_q;

endmodule
